// File: rtl/token_pkg.sv
// Shared types for the token run-length encoder: record layout and FSM encoding.
// Ports: none (package).
// Optional build macro used by this block: TOKEN_RUN_FLUSH_EN (adds a flush input to the top).
package token_pkg;

  // Default record length width; the top re-declares the record with its own LEN_W.
  localparam int LEN_W = 8;

  typedef struct packed {
    logic             sat;
    logic [LEN_W-1:0] len;
  } run_rec_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } run_state_e;

  // Plain-vector state constants for legacy tooling that dislikes enum-typed regs.
  localparam logic [0:0] ST_IDLE = IDLE;
  localparam logic [0:0] ST_RUN  = RUN;

endpackage

// File: rtl/token_rec_fifo.sv
// Synchronous record FIFO for run-length records, depth FIFO_DEPTH (power of two, >= 2).
// Ports: clk, rst (sync, active-high), push_i/push_dat_i, pop_i, head_dat_o, full_o, empty_o.
// A push while full succeeds only when a pop happens on the same edge; a pop while empty is ignored.
module token_rec_fifo
  import token_pkg::*;
#(
  parameter type rec_t      = run_rec_t,
  parameter int  FIFO_DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push_i,
  input  rec_t push_dat_i,
  input  logic pop_i,
  output rec_t head_dat_o,
  output logic full_o,
  output logic empty_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  // One extra pointer bit distinguishes full from empty when addresses match.
  logic [AW:0] wr_q, wr_d;
  logic [AW:0] rd_q, rd_d;
  rec_t        mem_q [FIFO_DEPTH];
  logic        do_push;
  logic        do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);

  assign do_pop  = pop_i && !empty_o;
  // The slot freed by a same-edge pop makes room for the push.
  assign do_push = push_i && (!full_o || do_pop);

  assign wr_d = do_push ? wr_q + 1'b1 : wr_q;
  assign rd_d = do_pop  ? rd_q + 1'b1 : rd_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_q[AW-1:0]] <= push_dat_i;
    end
  end

  // Storage is not reset; present zeros while empty so the head reads clean after reset.
  assign head_dat_o = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

endmodule

// File: rtl/token_run_length.sv
// Serial run-length encoder: measures runs of 1 tokens and queues {sat,len} records for a valid/ready consumer.
// Ports: clk, rst (sync, active-high), in_bit, out_valid/out_ready/out_len/out_sat, drop (sticky), busy,
//        flush (only when TOKEN_RUN_FLUSH_EN is defined: closes an open run as a 0 would).
module token_run_length
  import token_pkg::*;
#(
  parameter  int MAX_RUN    = 255,
  parameter  int FIFO_DEPTH = 4,
  localparam int LEN_W      = $clog2(MAX_RUN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_bit,
`ifdef TOKEN_RUN_FLUSH_EN
  input  logic             flush,
`endif
  input  logic             out_ready,
  output logic             out_valid,
  output logic [LEN_W-1:0] out_len,
  output logic             out_sat,
  output logic             drop,
  output logic             busy
);

  typedef struct packed {
    logic             sat;
    logic [LEN_W-1:0] len;
  } rec_t;

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_RUN);

  logic [0:0]       state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;
  logic             drop_q, drop_d;
  logic             close_run;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;
  rec_t             push_rec;
  rec_t             head_rec;

  // A run ends on the first 0; a flush ends it too and swallows that cycle's bit.
`ifdef TOKEN_RUN_FLUSH_EN
  assign close_run = (state_q == ST_RUN) && (!in_bit || flush);
`else
  assign close_run = (state_q == ST_RUN) && !in_bit;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    case (state_q)
      ST_IDLE: begin
        if (in_bit) begin
          state_d = ST_RUN;
          cnt_d   = LEN_W'(1);
          sat_d   = 1'b0;
        end
      end
      default: begin
        if (close_run) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          sat_d   = 1'b0;
        end else if (cnt_q < MAX_LEN) begin
          cnt_d = cnt_q + LEN_W'(1);
        end else begin
          // Length pins at MAX_RUN; the flag tells the consumer it is a lower bound.
          sat_d = 1'b1;
        end
      end
    endcase
  end

  assign push_rec = '{sat: sat_q, len: cnt_q};
  assign pop      = out_valid && out_ready;
  assign drop_d   = drop_q || (close_run && fifo_full && !pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
      drop_q  <= drop_d;
    end
  end

  token_rec_fifo #(
    .rec_t      (rec_t),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (close_run),
    .push_dat_i (push_rec),
    .pop_i      (pop),
    .head_dat_o (head_rec),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign out_len   = head_rec.len;
  assign out_sat   = head_rec.sat;
  assign drop      = drop_q;
  assign busy      = (state_q == ST_RUN);

endmodule

// File: tb/tb_token_run_length.sv
module tb_token_run_length;

  localparam int MAX_RUN    = 15;
  localparam int FIFO_DEPTH = 4;
  localparam int LEN_W      = $clog2(MAX_RUN + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             in_bit;
  logic             out_ready;
  logic             out_valid;
  logic [LEN_W-1:0] out_len;
  logic             out_sat;
  logic             drop;
  logic             busy;
`ifdef TOKEN_RUN_FLUSH_EN
  logic             flush;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  token_run_length #(
    .MAX_RUN    (MAX_RUN),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_bit    (in_bit),
`ifdef TOKEN_RUN_FLUSH_EN
    .flush     (flush),
`endif
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_len   (out_len),
    .out_sat   (out_sat),
    .drop      (drop),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a bit, let one edge pass, then settle 1 time unit past the edge.
  task automatic send(input logic b);
    in_bit = b;
    @(posedge clk);
    #1;
  endtask

  task automatic ones(input int n);
    for (int i = 0; i < n; i++) send(1'b1);
  endtask

  task automatic check_head(input string tag, input int len, input logic sat);
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_len"},   out_len,   len);
    check({tag, "_sat"},   out_sat,   sat);
  endtask

  initial begin
    rst       = 1'b1;
    in_bit    = 1'b1;
    out_ready = 1'b0;
`ifdef TOKEN_RUN_FLUSH_EN
    flush     = 1'b0;
`endif
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_valid", out_valid, 0);
    check("rst_busy",  busy,      0);
    check("rst_drop",  drop,      0);
    check("rst_len",   out_len,   0);
    check("rst_sat",   out_sat,   0);
    rst = 1'b0;

    // Basic runs: 0110111001 then 0 -> (2,0) (3,0) (1,0)
    out_ready = 1'b1;
    send(1'b0);
    check("idle_busy", busy, 0);
    send(1'b1);
    check("run_busy", busy, 1);
    send(1'b1);
    check("run2_novalid", out_valid, 0);
    send(1'b0);
    check_head("rec2", 2, 1'b0);
    check("rec2_busy", busy, 0);
    send(1'b1);
    check("pop2_empty", out_valid, 0);
    ones(2);
    send(1'b0);
    check_head("rec3", 3, 1'b0);
    send(1'b0);
    check("pop3_empty", out_valid, 0);
    send(1'b1);
    send(1'b0);
    check_head("rec1", 1, 1'b0);
    send(1'b0);
    check("pop1_empty", out_valid, 0);

    // Saturation: 20 ones -> (15,1), then run of 4 -> (4,0)
    ones(20);
    check("sat_busy", busy, 1);
    check("sat_novalid", out_valid, 0);
    send(1'b0);
    check_head("recsat", 15, 1'b1);
    ones(4);
    check("sat_popped", out_valid, 0);
    send(1'b0);
    check_head("rec4", 4, 1'b0);
    send(1'b0);
    check("pop4_empty", out_valid, 0);

    // Overflow: runs 1..5 with no consumer; run 5 is lost
    out_ready = 1'b0;
    for (int r = 1; r <= 4; r++) begin
      ones(r);
      send(1'b0);
    end
    check_head("full_head", 1, 1'b0);
    check("full_nodrop", drop, 0);
    ones(5);
    send(1'b0);
    check("ovf_drop", drop, 1);
    check_head("ovf_head", 1, 1'b0);
    out_ready = 1'b1;
    send(1'b0);
    check_head("drain2", 2, 1'b0);
    send(1'b0);
    check_head("drain3", 3, 1'b0);
    send(1'b0);
    check_head("drain4", 4, 1'b0);
    send(1'b0);
    check("drain_empty", out_valid, 0);
    check("drop_sticky", drop, 1);
    rst = 1'b1;
    send(1'b0);
    rst = 1'b0;
    check("drop_cleared", drop, 0);

    // Full FIFO with a pop on the same edge as the terminator: run 5 is kept
    out_ready = 1'b0;
    for (int r = 1; r <= 4; r++) begin
      ones(r);
      send(1'b0);
    end
    ones(5);
    out_ready = 1'b1;
    send(1'b0);
    check("simul_nodrop", drop, 0);
    check_head("simul2", 2, 1'b0);
    send(1'b0);
    check_head("simul3", 3, 1'b0);
    send(1'b0);
    check_head("simul4", 4, 1'b0);
    send(1'b0);
    check_head("simul5", 5, 1'b0);
    send(1'b0);
    check("simul_empty", out_valid, 0);

    // Reset mid-run abandons the open run
    ones(5);
    rst = 1'b1;
    send(1'b1);
    rst = 1'b0;
    check("midrst_busy",  busy,      0);
    check("midrst_valid", out_valid, 0);
    ones(2);
    send(1'b0);
    check_head("midrst_rec", 2, 1'b0);
    send(1'b0);
    check("midrst_only", out_valid, 0);

`ifdef TOKEN_RUN_FLUSH_EN
    // Flush closes a 3-run while in_bit stays high; that bit starts nothing
    ones(3);
    flush = 1'b1;
    send(1'b1);
    flush = 1'b0;
    check_head("flush_rec", 3, 1'b0);
    check("flush_busy", busy, 0);
    send(1'b0);
    check("flush_pop", out_valid, 0);
    check("flush_idle", busy, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/token_run_length.md
# token_run_length

Serial run-length encoder placed directly downstream of the token doubler. Samples one bit per cycle from the doubler's output stream, measures each run of consecutive `1` tokens, and queues one record per completed run into a small FIFO. The FIFO is drained through a valid/ready handshake by the checker or scoreboard logic that follows.

## Interface
Parameters:
- `MAX_RUN`, default 255: largest run length reported exactly; `LEN_W = $clog2(MAX_RUN+1)`.
- `FIFO_DEPTH`, default 4: record queue depth; power of two, ≥2.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset: synchronous, active-high.
- `in_bit`  in  1  serial token stream, one bit sampled per `clk` edge (doubler `b`).
- `out_valid`  out  1  head record available.
- `out_ready`  in  1  consumer accepts head record.
- `out_len`  out  LEN_W  run length of head record.
- `out_sat`  out  1  head record saturated: true run exceeded `MAX_RUN`.
- `drop`  out  1  sticky: at least one record was lost to a full FIFO.
- `busy`  out  1  a run is currently open (state RUN).
- `flush`  in  1  present only with `TOKEN_RUN_FLUSH_EN`.

## Operation
- FSM states:
  - IDLE, reset state.
  - RUN.
- IDLE:
  - `in_bit=1`: count←1, sat←0, go to RUN.
  - `in_bit=0`: stay in IDLE.
- RUN:
  - `in_bit=1`: if count<MAX_RUN then count←count+1, else count holds at MAX_RUN and sat←1.
  - `in_bit=0`: push {sat,count}, count←0, go to IDLE.
- Zero-length runs never produce records.
- Push when FIFO full:
  - If a pop occurs in the same cycle, the push succeeds.
  - Otherwise the record is discarded and `drop`←1.
  - `drop` clears only on `rst`.
- Pop occurs when `out_valid && out_ready`. `out_ready` with the FIFO empty is ignored.
- `out_len`/`out_sat` are held stable while `out_valid=1` and no pop occurs. Values are don't-care when `out_valid=0`.
- `busy` = (state==RUN).
- `rst`, including mid-run: state→IDLE, count→0, sat→0, FIFO emptied, `drop`→0. The open run is abandoned and no record is produced.

## Timing
- Reset values:
  - `out_valid`=0, `busy`=0, `drop`=0.
  - `out_len`=0, `out_sat`=0.
- Record latency: the first `0` after a run, sampled at edge t, makes the record visible at the FIFO output after edge t.
  - If the FIFO was empty, `out_valid`=1 in the cycle following edge t.
- Pop latency: next head is presented after the popping edge. FIFO throughput is one push and one pop per cycle.
- Minimum record spacing is 2 cycles (pattern `1010…`), so the FIFO never needs more than one push per cycle.
- `drop` asserts in the cycle after the failed push edge.

## Configuration
- `TOKEN_RUN_FLUSH_EN` defined:
  - Adds input `flush`.
  - `flush=1` in RUN closes the open run exactly as a `0` would, even if `in_bit=1`. That bit is consumed by the flush and does not start a new run.
  - `flush=1` in IDLE has no effect.
- `TOKEN_RUN_FLUSH_EN` undefined: port absent; runs close only on `in_bit=0` or `rst`.

## Structure
- Package `token_pkg`:
  - `typedef struct packed {logic sat; logic [LEN_W-1:0] len;} run_rec_t`, parameterised via package localparam default `LEN_W=8`.
  - State enum `run_state_e {IDLE, RUN}`.
- Sub-module `token_rec_fifo`:
  - Synchronous FIFO of `run_rec_t`, depth `FIFO_DEPTH`.
  - Pointers are one bit wider than the address; full/empty are derived from the pointers.
  - Supports simultaneous push/pop when full.
- Top level holds the FSM, length counter, saturation flag and drop logic.

## Test plan
- Reset: hold `rst` 2 cycles with `in_bit=1` → `out_valid=0`, `busy=0`, `drop=0`. First record after reset reflects only post-reset bits.
- Basic runs, `out_ready=1`: `in_bit` 0110111001 then 0 → records (2,0), (3,0), (1,0), each valid one cycle after its terminating `0`.
- Saturation, `MAX_RUN=15`: 20 ones then 0 → single record len=15, sat=1. A following run of 4 → (4,0).
- Backpressure/overflow, `FIFO_DEPTH=4`, `out_ready=0`: five runs `10` repeated → four records held, `drop=1` after the fifth terminator.
  - Then `out_ready=1`: records drain in order and `drop` stays 1 until `rst`.
- Full with simultaneous pop: FIFO full, `out_ready=1` on the same edge as a run terminator → push accepted, `drop` stays 0, order preserved.
- Reset mid-run: 5 ones, `rst` for one cycle, then 2 ones and 0 → exactly one record (2,0). With `TOKEN_RUN_FLUSH_EN`, `flush` during a 3-run → record (3,0) and `busy=0` next cycle.
